// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline sequencing controller for the 5-stage CPU. Drives the load
//   enables of the PC and the four pipeline latches, plus the bubble
//   (flush) controls of IF/ID, ID/EX and EX/MEM. Handles memory-wait
//   freezes, load-use bubbles, branch/jump flushes and the halt drain.
//
//   Optional feature macro: HAZARD_PERF_EN
//     defined   - stall_count counts RUN cycles with pc_en=0 (saturating).
//     undefined - stall_count is tied to 0, no counter is built.
//
// Ports
//   CLK, nRST          clock, asynchronous active-low reset
//   ihit, dhit         fetch / data access complete this cycle
//   dmem_req           EX/MEM holds a load or store
//   instr_id           IF/ID instruction (rs=[25:21], rt=[20:16])
//   halt_id, jump_id   HALT / jump currently in ID
//   MemRead_ex         ID/EX holds a load
//   wsel_ex            ID/EX destination register
//   branch_taken_mem   EX/MEM branch resolved taken
//   *_en               PC / latch load enables
//   *_flush            load a NOP bubble into the latch
//   halt_out           core halted (registered)
//   stall_count        performance counter
//
// state   | meaning
// RUN     | normal issue
// DRAIN   | HALT accepted, older instructions draining; drain_cnt = halt age
// HALTED  | halt reached MEM/WB; everything frozen until reset
module hazard_control #(
    parameter int CPUID = 0
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        dmem_req,
    input  logic [31:0] instr_id,
    input  logic        halt_id,
    input  logic        jump_id,
    input  logic        MemRead_ex,
    input  logic [4:0]  wsel_ex,
    input  logic        branch_taken_mem,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic        halt_out,
    output logic [31:0] stall_count
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DRAIN  = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

    logic [1:0] state, next_state;
    logic [1:0] drain_cnt, next_cnt;

    logic freeze, load_use;
    logic [4:0] rs, rt;

    logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
    logic ifid_flush_c, idex_flush_c, exmem_flush_c;

    // Fields of instr_id other than rs/rt and the CPUID parameter are not used.
    logic unused_bits;
    assign unused_bits = &{1'b0, instr_id[31:26], instr_id[15:0], CPUID[0]};

    assign rs       = instr_id[25:21];
    assign rt       = instr_id[20:16];
    assign freeze   = dmem_req & ~dhit;
    assign load_use = MemRead_ex & (wsel_ex != 5'd0) & ((wsel_ex == rs) | (wsel_ex == rt));

    always_comb begin
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        idex_en_c     = 1'b0;
        exmem_en_c    = 1'b0;
        memwb_en_c    = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        next_state    = state;
        next_cnt      = drain_cnt;

        // HALTED and freeze both leave every control low and hold state.
        if (state != ST_HALTED && !freeze) begin
            case (state)
                ST_RUN: begin
                    ifid_en_c  = 1'b1;
                    idex_en_c  = 1'b1;
                    exmem_en_c = 1'b1;
                    memwb_en_c = 1'b1;
                    if (branch_taken_mem) begin
                        pc_en_c       = 1'b1;
                        ifid_flush_c  = 1'b1;
                        idex_flush_c  = 1'b1;
                        exmem_flush_c = 1'b1;
                    end else if (load_use) begin
                        ifid_en_c    = 1'b0;
                        idex_flush_c = 1'b1;
                    end else if (halt_id) begin
                        ifid_flush_c = 1'b1;
                        next_state   = ST_DRAIN;
                        next_cnt     = 2'd1;
                    end else if (jump_id) begin
                        pc_en_c      = 1'b1;
                        ifid_flush_c = 1'b1;
                    end else begin
                        pc_en_c      = ihit;
                        ifid_flush_c = ~ihit;
                    end
                end
                ST_DRAIN: begin
                    ifid_en_c    = 1'b1;
                    idex_en_c    = 1'b1;
                    exmem_en_c   = 1'b1;
                    memwb_en_c   = 1'b1;
                    ifid_flush_c = 1'b1;
                    // A taken branch can still squash the halt while it is in ID/EX.
                    if (branch_taken_mem && drain_cnt == 2'd1) begin
                        pc_en_c       = 1'b1;
                        idex_flush_c  = 1'b1;
                        exmem_flush_c = 1'b1;
                        next_state    = ST_RUN;
                        next_cnt      = 2'd0;
                    end else if (drain_cnt == 2'd3) begin
                        next_state = ST_HALTED;
                        next_cnt   = 2'd0;
                    end else begin
                        next_cnt = drain_cnt + 2'd1;
                    end
                end
                default: begin
                    next_state = ST_RUN;
                    next_cnt   = 2'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= ST_RUN;
            drain_cnt <= 2'd0;
            halt_out  <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_cnt;
            halt_out  <= (next_state == ST_HALTED);
        end
    end

    // Controls are forced low while reset is held.
    assign pc_en       = nRST & pc_en_c;
    assign ifid_en     = nRST & ifid_en_c;
    assign idex_en     = nRST & idex_en_c;
    assign exmem_en    = nRST & exmem_en_c;
    assign memwb_en    = nRST & memwb_en_c;
    assign ifid_flush  = nRST & ifid_flush_c;
    assign idex_flush  = nRST & idex_flush_c;
    assign exmem_flush = nRST & exmem_flush_c;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= 32'd0;
        end else if (state == ST_RUN && !pc_en_c && stall_q != 32'hFFFF_FFFF) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`else
    assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_control.sv
module tb_hazard_control;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        ihit, dhit, dmem_req;
    logic [31:0] instr_id;
    logic        halt_id, jump_id, MemRead_ex;
    logic [4:0]  wsel_ex;
    logic        branch_taken_mem;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        halt_out;
    logic [31:0] stall_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: age of the accepted HALT in the pipeline.
    // 0 = no halt in flight, 1..3 = halt draining, 4 = halted.
    int          m_age;
    logic [31:0] m_stall;

    hazard_control #(.CPUID(0)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
        .instr_id(instr_id), .halt_id(halt_id), .jump_id(jump_id),
        .MemRead_ex(MemRead_ex), .wsel_ex(wsel_ex), .branch_taken_mem(branch_taken_mem),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
        .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
        .exmem_flush(exmem_flush), .halt_out(halt_out), .stall_count(stall_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Control vector order: {pc, ifid, idex, exmem, memwb, ifid_f, idex_f, exmem_f}
    function automatic void model(output logic [7:0] ctl, output int nxt);
        logic [31:0] ins;
        logic frz, lu;
        ins = instr_id;
        frz = dmem_req && !dhit;
        lu  = MemRead_ex && (wsel_ex != 0) &&
              (wsel_ex == ins[25:21] || wsel_ex == ins[20:16]);
        nxt = m_age;
        ctl = 8'b0;
        if (!nRST || m_age == 4 || frz)          ctl = 8'b0;
        else if (branch_taken_mem && m_age <= 1) begin ctl = 8'b11111_111; nxt = 0; end
        else if (m_age >= 1)                     begin ctl = 8'b01111_100; nxt = m_age + 1; end
        else if (lu)                             ctl = 8'b00111_010;
        else if (halt_id)                        begin ctl = 8'b01111_100; nxt = 1; end
        else if (jump_id)                        ctl = 8'b11111_100;
        else if (ihit)                           ctl = 8'b11111_000;
        else                                     ctl = 8'b01111_100;
    endfunction

    task automatic cycle();
        logic [7:0] exp_ctl;
        int nxt;
        @(negedge CLK);
        model(exp_ctl, nxt);
        check("ctl", {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                      ifid_flush, idex_flush, exmem_flush}, {24'd0, exp_ctl});
        check("halt_out", {31'd0, halt_out}, {31'd0, nRST && m_age == 4});
        check("stall_count", stall_count, nRST ? m_stall : 32'd0);
        @(posedge CLK);
        if (!nRST) begin
            m_age   = 0;
            m_stall = 0;
        end else begin
`ifdef HAZARD_PERF_EN
            if (m_age == 0 && !exp_ctl[7] && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
`endif
            m_age = nxt;
        end
        #1;
    endtask

    task automatic set_idle();
        ihit = 1; dhit = 1; dmem_req = 0; instr_id = 0; halt_id = 0; jump_id = 0;
        MemRead_ex = 0; wsel_ex = 0; branch_taken_mem = 0;
    endtask

    task automatic do_reset();
        nRST = 0;
        cycle();
        nRST = 1;
    endtask

    initial begin
        int edges;
        int halted_for;
        m_age = 0; m_stall = 0;
        set_idle();
        nRST = 0;
        #1;
        do_reset();
        check("reset_halt_out", {31'd0, halt_out}, 32'd0);

        // Memory freeze: 4 frozen cycles then release.
        dmem_req = 1; dhit = 0;
        repeat (4) cycle();
        dhit = 1;
        cycle();
        set_idle();

        // Load-use bubble and the r0 exception.
        MemRead_ex = 1; wsel_ex = 5'd8; instr_id = {6'd0, 5'd8, 5'd3, 16'd0};
        cycle();
        set_idle();
        cycle();
        MemRead_ex = 1; wsel_ex = 5'd0; instr_id = 32'd0;
        cycle();
        set_idle();

        // Branch beats load-use with ihit low.
        MemRead_ex = 1; wsel_ex = 5'd4; instr_id = {6'd0, 5'd1, 5'd4, 16'd0};
        ihit = 0; branch_taken_mem = 1;
        @(negedge CLK);
        check("branch_over_lu", {24'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                                 ifid_flush, idex_flush, exmem_flush}, 32'h0000_00FF);
        @(posedge CLK); #1;
        set_idle();

        // Halt latency without stalls.
        halt_id = 1;
        cycle();
        halt_id = 0;
        edges = 1;
        while (!halt_out && edges < 12) begin
            cycle();
            edges++;
        end
        check("halt_latency", edges, 4);
        cycle();
        do_reset();
        check("reset_from_halted", {31'd0, halt_out}, 32'd0);

        // Halt latency with two freeze cycles mid-drain.
        set_idle();
        halt_id = 1;
        cycle();
        halt_id = 0;
        edges = 1;
        while (!halt_out && edges < 12) begin
            dmem_req = (edges == 2 || edges == 3);
            dhit     = 0;
            cycle();
            edges++;
        end
        check("halt_latency_frz", edges, 6);
        set_idle();
        do_reset();

        // Branch squashes a freshly accepted halt.
        halt_id = 1;
        cycle();
        halt_id = 0; branch_taken_mem = 1;
        cycle();
        set_idle();
        repeat (6) cycle();
        check("drain_abort", {31'd0, halt_out}, 32'd0);

        // Perf counter: five fetch misses.
        do_reset();
        ihit = 0;
        repeat (5) cycle();
        set_idle();
        @(negedge CLK);
`ifdef HAZARD_PERF_EN
        check("stall_5", stall_count, 32'd5);
`else
        check("stall_tied", stall_count, 32'd0);
`endif
        @(posedge CLK); #1;
        ihit = 0;
        repeat (3) cycle();
        nRST = 0;
        #1;
        check("stall_reset", stall_count, 32'd0);
        @(posedge CLK); m_age = 0; m_stall = 0; #1;
        nRST = 1;
        set_idle();

        // Randomized traffic against the model.
        halted_for = 0;
        for (int i = 0; i < 3000; i++) begin
            ihit             = ($urandom_range(0, 99) < 80);
            dmem_req         = ($urandom_range(0, 99) < 30);
            dhit             = ($urandom_range(0, 99) < 60);
            branch_taken_mem = ($urandom_range(0, 99) < 10);
            halt_id          = ($urandom_range(0, 99) < 8);
            jump_id          = ($urandom_range(0, 99) < 15);
            MemRead_ex       = ($urandom_range(0, 99) < 30);
            wsel_ex          = 5'($urandom_range(0, 7));
            instr_id         = $urandom;
            instr_id[25:21]  = 5'($urandom_range(0, 7));
            instr_id[20:16]  = 5'($urandom_range(0, 7));
            halted_for       = (m_age == 4) ? halted_for + 1 : 0;
            nRST             = !(halted_for > 3 || $urandom_range(0, 199) == 0);
            cycle();
        end
        nRST = 1;
        set_idle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipeline sequencing controller for the 5-stage CPU. It sits beside the forwarding hazard unit and drives the enable and flush controls of the PC and the four pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB). It handles memory-wait freezes, load-use bubbles, taken-branch and jump flushes, and the halt-drain sequence. The halt-drain sequence is the stateful part of the block.

## Interface
Parameters:
- CPUID, default 0, core index; carried for multi-core builds and has no functional effect.

Ports:
- CLK  in  1  core clock; all state updates on rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- dmem_req  in  1  the EX/MEM latch holds a load or store (dREN|dWEN).
- instr_id  in  word_t  IF/ID instruction; rs=[25:21], rt=[20:16].
- halt_id  in  1  the IF/ID instruction is HALT.
- jump_id  in  1  J/JAL/JR resolved in ID.
- MemRead_ex  in  1  the ID/EX instruction is a load.
- wsel_ex  in  regbits_t  ID/EX destination register.
- branch_taken_mem  in  1  the EX/MEM branch resolved taken.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch/PC load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a NOP bubble when the latch is enabled.
- halt_out  out  1  core halted; registered.
- stall_count  out  32  perf counter (see Configuration).

## Operation
- While nRST=0, every output is 0. After reset the state is RUN and drain_cnt=0.
- States: RUN, DRAIN, HALTED. drain_cnt is 2 bits and only meaningful in DRAIN.
- `freeze = dmem_req & !dhit`. When freeze is set:
  - all five enables are 0 and all flushes are 0;
  - state and drain_cnt hold;
  - freeze has priority over everything except HALTED.
- `load_use = MemRead_ex & (wsel_ex != 0) & (wsel_ex == rs | wsel_ex == rt)`.

RUN, not frozen, first matching rule applies:
1. branch_taken_mem: all enables 1; ifid_flush=idex_flush=exmem_flush=1; pc_en=1 even if ihit=0.
2. load_use: pc_en=0, ifid_en=0, idex_flush=1; idex/exmem/memwb enabled.
3. jump_id: all enables 1, ifid_flush=1 (the delay-slot fetch is discarded).
4. Otherwise all enables 1. If ihit=0, then pc_en=0 and ifid_flush=1.
- Transition RUN to DRAIN, drain_cnt=1, when halt_id=1, not frozen, no load_use and no branch_taken_mem. In this cycle pc_en=0 and ifid_flush=1.

DRAIN, not frozen:
- pc_en=0 and ifid_flush=1. All other enables are 1. drain_cnt increments.
- branch_taken_mem with drain_cnt=1 (the halt is younger, sitting in ID/EX): apply the RUN rule 1 flushes and return to RUN with drain_cnt=0.
- drain_cnt=3 (the halt has entered MEM/WB): go to HALTED.

HALTED:
- All enables 0, halt_out=1. Only nRST exits this state.

## Timing
- All enables and flushes are combinational from the current inputs and state, in the same cycle.
- halt_out and the state are registered, one cycle after the qualifying edge.
- Halt latency: from the cycle the halt is in ID to halt_out=1 is exactly 3 non-frozen cycles plus 1. Frozen cycles are added on top.
- Simultaneous events:
  - branch_taken_mem beats halt_id, load_use and jump_id.
  - freeze beats branch_taken_mem: the branch is held until dhit.
- Reset mid-DRAIN or in HALTED returns to RUN immediately, asynchronously.

## Configuration
- HAZARD_PERF_EN defined: stall_count increments each RUN cycle with pc_en=0. It saturates at 0xFFFFFFFF and resets to 0.
- HAZARD_PERF_EN undefined: stall_count is tied to 0 and no counter logic is built.

## Test plan
- dmem_req=1, dhit=0 for 4 cycles, then dhit=1 → enables 0 for 4 cycles, all 1 in cycle 5, state unchanged.
- MemRead_ex=1, wsel_ex=8, instr_id rs=8 → pc_en=0, ifid_en=0, idex_flush=1 for exactly 1 cycle. With wsel_ex=0 there is no bubble.
- branch_taken_mem=1 together with load_use=1 and ihit=0 → pc_en=1 and all three flushes set; no bubble.
- halt_id=1 with no stalls → DRAIN, then halt_out=1 four edges later. Inserting 2 freeze cycles mid-drain gives six edges later.
- halt_id enters DRAIN, then branch_taken_mem=1 on the next cycle → state RUN, halt_out stays 0, flushes asserted.
- With HAZARD_PERF_EN: 5 ihit=0 cycles give stall_count=5. Without the macro stall_count=0. nRST low mid-count gives 0.
